// File: rtl/seg7_disp_arbiter.sv
// seg7_disp_arbiter
// Shares one 6-digit seven-segment display between two requesters.
// Requester 0 has fixed priority out of IDLE. Each owner keeps the display for
// at least HOLD_CYC cycles. After that, a waiting requester takes over
// (round-robin), so neither side can starve the other. Every output is a
// register, so each decision becomes visible one cycle after the inputs are
// sampled.
module seg7_disp_arbiter #(
  parameter int unsigned HOLD_CYC = 50_000_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [23:0] data0,
  input  logic        req1,
  input  logic [23:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [23:0] disp_data,
  output logic        disp_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // Terminal value of the hold counter; the counter parks here once reached.
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic             hold_done;

  // Minimum hold has elapsed. With HOLD_CYC=1 this is already true on the entry cycle.
  assign hold_done = (hold_cnt == HOLD_MAX);

  // Arbitration FSM with registered grants and data path.
  // The state, the grants and disp_data are updated together on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      disp_data  <= 24'h0;
      disp_valid <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Requester 0 wins a tie out of idle.
          if (req0) begin
            state      <= OWN0;
            gnt0       <= 1'b1;
            gnt1       <= 1'b0;
            disp_data  <= data0;
            disp_valid <= 1'b1;
            hold_cnt   <= '0;
          end else if (req1) begin
            state      <= OWN1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b1;
            disp_data  <= data1;
            disp_valid <= 1'b1;
            hold_cnt   <= '0;
          end else begin
            // Blank the display but keep the last word, so nothing is lost
            // when it is shown again.
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            disp_valid <= 1'b0;
          end
        end

        OWN0: begin
          if (!hold_done) begin
            // Still inside the guaranteed hold. Requester 1 must wait.
            // If req0 has dropped, the data freezes.
            hold_cnt <= hold_cnt + CNT_W'(1);
            if (req0) begin
              disp_data <= data0;
            end
          end else if (req1) begin
            // Hand the display over to the other requester.
            state      <= OWN1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b1;
            disp_data  <= data1;
            disp_valid <= 1'b1;
            hold_cnt   <= '0;
          end else if (req0) begin
            // Nobody is waiting. Keep ownership with the counter saturated.
            disp_data <= data0;
          end else begin
            state      <= IDLE;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            disp_valid <= 1'b0;
          end
        end

        OWN1: begin
          if (!hold_done) begin
            // Requester 0 cannot pre-empt during the hold.
            hold_cnt <= hold_cnt + CNT_W'(1);
            if (req1) begin
              disp_data <= data1;
            end
          end else if (req0) begin
            state      <= OWN0;
            gnt0       <= 1'b1;
            gnt1       <= 1'b0;
            disp_data  <= data0;
            disp_valid <= 1'b1;
            hold_cnt   <= '0;
          end else if (req1) begin
            disp_data <= data1;
          end else begin
            state      <= IDLE;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            disp_valid <= 1'b0;
          end
        end

        default: begin
          // Unreachable encoding. Recover to a blank, idle display.
          state      <= IDLE;
          gnt0       <= 1'b0;
          gnt1       <= 1'b0;
          disp_valid <= 1'b0;
          hold_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_disp_arbiter.sv
// Directed testbench for seg7_disp_arbiter with HOLD_CYC=4.
// Inputs change 1 ns after a rising edge. Outputs are checked at that same
// point, so each check reflects the edge just taken.
module tb_seg7_disp_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0;
  logic [23:0] data0;
  logic        req1;
  logic [23:0] data1;
  logic        gnt0;
  logic        gnt1;
  logic [23:0] disp_data;
  logic        disp_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  seg7_disp_arbiter #(
    .HOLD_CYC(4),
    .CNT_W   (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .data0     (data0),
    .req1      (req1),
    .data1     (data1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .disp_data (disp_data),
    .disp_valid(disp_valid)
  );

  always #5 clk = ~clk;

  // Single comparison point. It counts the comparison and reports any difference.
  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end else begin
      $display("[TB] ok   %s = %h", tag, observed);
    end
  endtask

  // Checks all four outputs against the expected values.
  task automatic check_out(input string tag, input logic eg0, input logic eg1,
                           input logic ev, input logic [23:0] ed);
    check({tag, ".gnt0"},  32'(gnt0),       32'(eg0));
    check({tag, ".gnt1"},  32'(gnt1),       32'(eg1));
    check({tag, ".valid"}, 32'(disp_valid), 32'(ev));
    check({tag, ".data"},  32'(disp_data),  32'(ed));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = 24'h0; data1 = 24'h0;

    // 1: reset state, then idle with no requests.
    step(2);
    check_out("reset", 1'b0, 1'b0, 1'b0, 24'h0);
    rst = 1'b0;
    step(2);
    check_out("idle", 1'b0, 1'b0, 1'b0, 24'h0);

    // 2: single grant with one cycle of latency, then a live data update.
    req0 = 1'b1; data0 = 24'h123456;
    step(1);
    check_out("grant0", 1'b1, 1'b0, 1'b1, 24'h123456);
    data0 = 24'hABCDEF;
    step(1);
    check_out("live0", 1'b1, 1'b0, 1'b1, 24'hABCDEF);
    req0 = 1'b0;
    step(2);
    check_out("hold0_end", 1'b1, 1'b0, 1'b1, 24'hABCDEF);
    step(1);
    check_out("release0", 1'b0, 1'b0, 1'b0, 24'hABCDEF);

    // 3: tie from IDLE goes to requester 0. Grants then alternate 0,1,0 for 4 cycles each.
    req0 = 1'b1; data0 = 24'h111111; req1 = 1'b1; data1 = 24'h222222;
    for (int g = 0; g < 3; g++) begin
      for (int c = 0; c < 4; c++) begin
        step(1);
        if (g == 1)
          check_out($sformatf("rr_g%0d_c%0d", g, c), 1'b0, 1'b1, 1'b1, 24'h222222);
        else
          check_out($sformatf("rr_g%0d_c%0d", g, c), 1'b1, 1'b0, 1'b1, 24'h111111);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step(1);
    check_out("rr_idle", 1'b0, 1'b0, 1'b0, 24'h111111);

    // 4: req0 rises at hold_cnt=1 during OWN1. Requester 1 keeps the display to the end of its hold.
    req1 = 1'b1; data1 = 24'h0000B1;
    step(1);
    check_out("own1_c0", 1'b0, 1'b1, 1'b1, 24'h0000B1);
    step(1);
    req0 = 1'b1; data0 = 24'h0000A0; data1 = 24'h0000B2;
    step(1);
    check_out("own1_c2", 1'b0, 1'b1, 1'b1, 24'h0000B2);
    step(1);
    check_out("own1_c3", 1'b0, 1'b1, 1'b1, 24'h0000B2);
    step(1);
    check_out("handover0", 1'b1, 1'b0, 1'b1, 24'h0000A0);
    req0 = 1'b0; req1 = 1'b0;
    step(4);
    check_out("own0_idle", 1'b0, 1'b0, 1'b0, 24'h0000A0);

    // 5: req0 drops at hold_cnt=0. Data freezes and the grant is kept for 4 cycles.
    req0 = 1'b1; data0 = 24'h555555;
    step(1);
    check_out("drop_c0", 1'b1, 1'b0, 1'b1, 24'h555555);
    req0 = 1'b0; data0 = 24'h999999;
    step(1);
    check_out("drop_c1", 1'b1, 1'b0, 1'b1, 24'h555555);
    step(2);
    check_out("drop_c3", 1'b1, 1'b0, 1'b1, 24'h555555);
    step(1);
    check_out("drop_idle", 1'b0, 1'b0, 1'b0, 24'h555555);

    // 6: reset in the middle of OWN1 at hold_cnt=2, then req1 is granted again.
    req1 = 1'b1; data1 = 24'h666666;
    step(3);
    check_out("own1_pre_rst", 1'b0, 1'b1, 1'b1, 24'h666666);
    rst = 1'b1;
    step(1);
    check_out("mid_rst", 1'b0, 1'b0, 1'b0, 24'h0);
    rst = 1'b0;
    step(1);
    check_out("regrant1", 1'b0, 1'b1, 1'b1, 24'h666666);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
